// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized rx, mid-bit sampling, one-cycle
// data_valid / frame_err strobes, and break suppression after a bad stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data       <= shift_reg;
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // Held-low line must return high before another start bit is accepted.
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: behavioural serializer plus an event-queue model that
// predicts every data_valid / frame_err pulse and the held data value.
module tb_uart_rx;

  localparam int CLKS = 16;
  localparam int HALF = CLKS / 2;
  // Start edge to strobe: 2 sync flops + start detect, half bit, 9 full bits.
  localparam int LAT  = 9 * CLKS + HALF + 3;

  typedef struct {
    int unsigned cyc;
    bit          good;
    logic [7:0]  b;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned cyc = 0;
  bit          run = 1'b0;
  ev_t         exp_q[$];
  logic [7:0]  model_data = '0;
  bit          ev_v, ev_e;

  int unsigned valid_cnt = 0, err_cnt = 0;
  int unsigned last_valid_cyc = 0, prev_valid_cyc = 0, busy_fall_cyc = 0;
  logic        busy_q = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data),
    .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the event queue.
  always @(negedge clk) begin
    if (run && !rst) begin
      ev_v = 1'b0;
      ev_e = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        if (exp_q[0].good) begin
          ev_v       = 1'b1;
          model_data = exp_q[0].b;
        end else begin
          ev_e = 1'b1;
        end
        void'(exp_q.pop_front());
      end
      chk("data_valid", 32'(data_valid), 32'(ev_v));
      chk("frame_err", 32'(frame_err), 32'(ev_e));
      chk("data", 32'(data), 32'(model_data));
    end
  end

  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (busy_q && !busy) busy_fall_cyc = cyc;
    busy_q = busy;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, output int unsigned p);
    logic [9:0] bits;
    ev_t e;
    bits  = {stop_ok, b, 1'b0};
    p     = cyc;
    e.cyc = p + LAT;
    e.good = stop_ok;
    e.b   = b;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CLKS) @(negedge clk);
    end
  endtask

  initial begin
    int unsigned p, v0, e0;
    string msg;
    logic [7:0] rb;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_valid", 32'(data_valid), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    idle(4);

    // 'H'
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h48, 1'b1, p);
    idle(2 * CLKS);
    chk("h_count", valid_cnt - v0, 1);
    chk("h_errs", err_cnt - e0, 0);
    chk("h_data", 32'(data), 32'h48);
    chk("h_latency", last_valid_cyc - p, 155);
    chk("h_busy_fall", busy_fall_cyc - p, 155);

    // back-to-back 0x55, 0xAA
    v0 = valid_cnt;
    send_frame(8'h55, 1'b1, p);
    chk("b2b_first", 32'(data), 32'h55);
    send_frame(8'hAA, 1'b1, p);
    idle(2 * CLKS);
    chk("b2b_count", valid_cnt - v0, 2);
    chk("b2b_spacing", last_valid_cyc - prev_valid_cyc, 160);
    chk("b2b_data", 32'(data), 32'hAA);

    // 5-cycle glitch
    v0 = valid_cnt; e0 = err_cnt;
    p = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_seen", 32'(busy), 32'h1);
    @(negedge clk);
    rx = 1'b1;
    repeat (HALF + 3 - 5) @(negedge clk);
    chk("glitch_idle_cycle", cyc - p, HALF + 3);
    chk("glitch_busy_clear", 32'(busy), 32'h0);
    idle(CLKS);
    chk("glitch_no_valid", valid_cnt - v0, 0);
    chk("glitch_no_err", err_cnt - e0, 0);

    // bad stop, break hold, recovery
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, p);
    repeat (100) @(negedge clk);
    chk("brk_err_count", err_cnt - e0, 1);
    chk("brk_no_valid", valid_cnt - v0, 0);
    chk("brk_data_held", 32'(data), 32'hAA);
    idle(2 * CLKS);
    send_frame(8'h0D, 1'b1, p);
    idle(2 * CLKS);
    chk("brk_recover_count", valid_cnt - v0, 1);
    chk("brk_recover_data", 32'(data), 32'h0D);

    // async reset during bit 4 of 0xFF
    v0 = valid_cnt;
    fork
      send_frame(8'hFF, 1'b1, p);
      begin
        repeat (90) @(posedge clk);
        #3;
        chk("rst_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        exp_q.delete();
        model_data = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
      end
    join
    idle(CLKS);
    send_frame(8'h0A, 1'b1, p);
    idle(2 * CLKS);
    chk("rst_after_count", valid_cnt - v0, 1);
    chk("rst_after_data", 32'(data), 32'h0A);

    // loopback string at line rate
    msg = "Hello from UART!\r\n";
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < msg.len(); i++) begin
      rb = msg[i];
      send_frame(rb, 1'b1, p);
    end
    idle(2 * CLKS);
    chk("loop_count", valid_cnt - v0, 18);
    chk("loop_errs", err_cnt - e0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int unsigned r;
      r  = $urandom_range(0, 9);
      rb = 8'($urandom_range(0, 255));
      if (r == 0) begin
        rx = 1'b0;
        repeat ($urandom_range(1, HALF - 2)) @(negedge clk);
        idle(CLKS);
      end else if (r == 1) begin
        send_frame(rb, 1'b0, p);
        repeat ($urandom_range(10, 60)) @(negedge clk);
        idle($urandom_range(4, 20));
      end else begin
        send_frame(rb, 1'b1, p);
        idle($urandom_range(0, 20));
      end
    end
    idle(LAT + CLKS);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
